// File: rtl/check_node_unit.sv
// Log-domain sum-product LDPC check-node processor: collects one check's messages, then emits extrinsic replies.
// Optional build macro CNU_CHECK_CNT_EN adds the chk_cnt completed-check counter port.

module phi_lut (
    input  logic [5:0] x,
    output logic [3:0] y
);
    // phi(x) = log((1+e^-x)/(1-e^-x)), x in 2.4, y in 2.2, round-to-nearest, saturate at 15
    always_comb begin
        if      (x == 6'd0)  y = 4'd15;
        else if (x == 6'd1)  y = 4'd14;
        else if (x == 6'd2)  y = 4'd11;
        else if (x == 6'd3)  y = 4'd9;
        else if (x == 6'd4)  y = 4'd8;
        else if (x <= 6'd6)  y = 4'd7;
        else if (x <= 6'd8)  y = 4'd6;
        else if (x <= 6'd10) y = 4'd5;
        else if (x <= 6'd14) y = 4'd4;
        else if (x <= 6'd19) y = 4'd3;
        else if (x <= 6'd26) y = 4'd2;
        else if (x <= 6'd44) y = 4'd1;
        else                 y = 4'd0;
    end
endmodule

module check_node_unit #(
    parameter int MAX_DEG = 8,
    parameter int SUM_W   = 4 + $clog2(MAX_DEG)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [5:0]  in_mag,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [5:0]  out_mag,
    output logic        out_last,
    output logic        deg_err,
`ifdef CNU_CHECK_CNT_EN
    output logic [15:0] chk_cnt,
`endif
    output logic        state_dbg
);
    localparam int IDX_W = $clog2(MAX_DEG);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_EMIT    = 1'b1;

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // producer holds its data stable from raising valid until that edge.

    logic [0:0]       state;
    logic [SUM_W-1:0] s_sum;
    logic             p_par;
    logic [IDX_W-1:0] wr_idx;
    logic [CNT_W-1:0] rd_idx;
    logic [CNT_W-1:0] deg;
    logic [3:0]       buf_phi  [MAX_DEG];
    logic             buf_sign [MAX_DEG];

    logic [3:0]       phi_in;
    logic [3:0]       phi_out;
    logic [SUM_W-1:0] ext;
    logic [5:0]       lut_x;
    logic [IDX_W-1:0] rd_ptr;
    logic             acc;
    logic             wr_last;
    logic             load;
    logic             emit_last;

    assign in_ready  = (state == ST_COLLECT);
    assign state_dbg = state;
    assign acc       = in_valid && in_ready;
    assign wr_last   = (wr_idx == IDX_W'(MAX_DEG - 1));
    assign rd_ptr    = rd_idx[IDX_W-1:0];

    // Extrinsic sum is re-scaled 2.2 -> 2.4 and saturated to the LUT input range
    assign ext       = s_sum - SUM_W'(buf_phi[rd_ptr]);
    assign lut_x     = (ext > SUM_W'(15)) ? 6'd63 : {ext[3:0], 2'b00};
    assign load      = (state == ST_EMIT) && (!out_valid || out_ready);
    assign emit_last = (rd_idx == deg - CNT_W'(1));

    phi_lut u_phi_in  (.x(in_mag), .y(phi_in));
    phi_lut u_phi_out (.x(lut_x),  .y(phi_out));

    // Edge buffer carries no reset: it is always rewritten before being read
    always_ff @(posedge clk) begin
        if (acc) begin
            buf_phi[wr_idx]  <= phi_in;
            buf_sign[wr_idx] <= in_sign;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_COLLECT;
            s_sum     <= '0;
            p_par     <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            deg       <= '0;
            deg_err   <= 1'b0;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_mag   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (acc) begin
                s_sum  <= s_sum + SUM_W'(phi_in);
                p_par  <= p_par ^ in_sign;
                wr_idx <= wr_idx + IDX_W'(1);
                if (in_last || wr_last) begin
                    state  <= ST_EMIT;
                    deg    <= CNT_W'(wr_idx) + CNT_W'(1);
                    rd_idx <= '0;
                    if (!in_last) begin
                        deg_err <= 1'b1;
                    end
                end
            end

            if (load) begin
                out_valid <= 1'b1;
                out_sign  <= p_par ^ buf_sign[rd_ptr];
                out_mag   <= {phi_out, 2'b00};
                out_last  <= emit_last;
                rd_idx    <= rd_idx + CNT_W'(1);
                if (emit_last) begin
                    state  <= ST_COLLECT;
                    s_sum  <= '0;
                    p_par  <= 1'b0;
                    wr_idx <= '0;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CNU_CHECK_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_cnt <= '0;
        end else if (out_valid && out_ready && out_last) begin
            chk_cnt <= chk_cnt + 16'd1;
        end
    end
`endif

endmodule
